bt_tx_arbiter: RTL and testbench
================================

// Module: bt_tx_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing the Bluetooth UART transmit character FIFO (tx_data/tx_buf_en/tx_buf_full)
//  among NUM_REQ byte-stream requesters. A granted requester owns the FIFO write port until its last byte, an idle
//  timeout or the max-length cap, so packets from different sources never interleave on the RS232 link.
// PARAMETERS
//  NUM_REQ       4     number of requesters (2..8)
//  MAX_PKT_LEN   64    max bytes per grant; forced release after this many bytes (1..255)
//  IDLE_TIMEOUT  1000  consecutive clk_rx cycles with granted req_valid low before abort (1..65535)
// PORTS
//  clk_rx        in   1          clock; same domain as the FIFO write side
//  rst_clk_rx    in   1          synchronous active-high reset, synchronized to clk_rx
//  req_valid     in   NUM_REQ    per-requester byte valid
//  req_data      in   8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
//  req_last      in   NUM_REQ    marks final byte of packet, qualified by req_valid
//  req_ready     out  NUM_REQ    per-requester accept; byte transfers when valid & ready
//  tx_data       out  8          byte to character FIFO
//  tx_buf_en     out  1          FIFO write enable
//  tx_buf_full   in   1          FIFO full
//  grant         out  NUM_REQ    one-hot current owner, 0 when idle
//  busy          out  1          1 while in GRANT
//  abort_pulse   out  1          1-cycle pulse: grant dropped by idle timeout
//  trunc_pulse   out  1          1-cycle pulse: grant dropped by MAX_PKT_LEN without req_last
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, busy=0, pulses=0, req_ready=0, tx_buf_en=0, tx_data=0, byte_cnt=0, idle_cnt=0,
//    last_ptr=NUM_REQ-1 (requester 0 has highest priority after reset). Reset mid-packet drops grant immediately.
//  - States: IDLE, GRANT (registered). grant, busy registered; req_ready/tx_buf_en/tx_data combinational from them.
//  - IDLE: if any req_valid, select first i with req_valid[i] searching last_ptr+1, +2, ... modulo NUM_REQ;
//    next cycle state=GRANT, grant=onehot(i), byte_cnt=0, idle_cnt=0. Arbitration latency 1 cycle; no transfer in IDLE.
//  - GRANT (owner g): req_ready[g]=!tx_buf_full, others 0. tx_buf_en=req_valid[g]&!tx_buf_full; tx_data=req_data[g]
//    (tx_data=0 when not GRANT). Zero-latency pass-through; never write while tx_buf_full=1.
//  - Per accepted byte: byte_cnt+=1, idle_cnt=0. Cycle with req_valid[g]=0: idle_cnt+=1. Cycle with valid=1 but
//    tx_buf_full=1: idle_cnt holds (backpressure is not idleness).
//  - Release (next cycle state=IDLE, grant=0, last_ptr=g), priority order:
//    1) accepted byte with req_last[g]=1 -> normal release, no pulse;
//    2) accepted byte making byte_cnt==MAX_PKT_LEN without last -> trunc_pulse=1 next cycle;
//    3) idle_cnt reaches IDLE_TIMEOUT -> abort_pulse=1 next cycle.
//  - Released requester cannot be re-granted in the following IDLE cycle if another is valid (round-robin fairness).
//  - Single requester: back-to-back packets separated by exactly one IDLE cycle.
//  - byte_cnt 8 bits, idle_cnt 16 bits, both saturate; never wrap.
//  - req_last without req_valid ignored. Requester changing req_data while valid & !ready is a protocol violation.
// TESTING
//  - Reset then req0 sends 3 bytes 0x41,0x42,0x43(last), FIFO not full -> grant=0001 one cycle after valid, 3 tx_buf_en
//    cycles with those bytes in order, then grant=0.
//  - req0,req1,req2 all valid continuously with 2-byte packets -> grant order 0,1,2,0,1,2; no interleaved bytes.
//  - tx_buf_full=1 for 10 cycles mid-packet -> tx_buf_en=0 and req_ready=0 those cycles, no byte lost, no abort.
//  - IDLE_TIMEOUT=8, owner drops valid after 1 byte -> abort_pulse exactly 8 cycles after last valid, next requester granted.
//  - MAX_PKT_LEN=4, req1 streams 6 bytes no last -> 4 bytes written, trunc_pulse, other valid requester granted next.
//  - rst_clk_rx asserted during byte 2 of a packet -> next cycle grant=0, tx_buf_en=0; after reset req0 wins a tie.

Source files
------------

// File: rtl/bt_tx_arbiter.sv
// Packet-level round-robin arbiter for the Bluetooth UART tx FIFO write port; 1-cycle arbitration then zero-latency pass-through.
// tx_buf_full drops the owner's req_ready and blocks writes; stalled cycles are not counted as idle.
module bt_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_PKT_LEN  = 64,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                 clk_rx,
    input  logic                 rst_clk_rx,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_buf_en,
    input  logic                 tx_buf_full,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 abort_pulse,
    output logic                 trunc_pulse
);
    localparam int                 IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]         MAX_LEN  = 8'(MAX_PKT_LEN);
    localparam logic [15:0]        IDLE_LIM = 16'(IDLE_TIMEOUT);
    localparam logic [IW-1:0]      LAST_REQ = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      last_ptr_q, last_ptr_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic [15:0]        idle_cnt_q, idle_cnt_d, idle_cnt_inc;
    logic [NUM_REQ-1:0] grant_d;
    logic               abort_d, trunc_d;
    logic               own_vld, own_last, accept;
    logic [7:0]         own_dat;
    logic [IW-1:0]      pick_idx, cand;
    logic               pick_vld;

    assign own_vld  = req_valid[owner_q];
    assign own_last = req_last[owner_q];
    assign own_dat  = req_data[{owner_q, 3'b000} +: 8];
    assign accept   = (state_q == ST_GRANT) && own_vld && !tx_buf_full;
    assign busy     = (state_q == ST_GRANT);

    // Search starts just after the previous owner, so it has lowest priority next round.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        tx_buf_en = 1'b0;
        tx_data   = '0;
        if (state_q == ST_GRANT) begin
            req_ready[owner_q] = !tx_buf_full;
            tx_buf_en          = accept;
            tx_data            = own_dat;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_ptr_d   = last_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        abort_d      = 1'b0;
        trunc_d      = 1'b0;
        byte_cnt_inc = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
        idle_cnt_inc = (idle_cnt_q == 16'hFFFF) ? idle_cnt_q : idle_cnt_q + 16'd1;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_inc;
                    idle_cnt_d = '0;
                    if (own_last) begin
                        state_d    = ST_IDLE;
                        last_ptr_d = owner_q;
                    end else if (byte_cnt_inc >= MAX_LEN) begin
                        state_d    = ST_IDLE;
                        last_ptr_d = owner_q;
                        trunc_d    = 1'b1;
                    end
                end else if (!own_vld) begin
                    // A full FIFO with valid data holds the counter: backpressure is not idleness.
                    idle_cnt_d = idle_cnt_inc;
                    if (idle_cnt_inc >= IDLE_LIM) begin
                        state_d    = ST_IDLE;
                        last_ptr_d = owner_q;
                        abort_d    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        grant_d = (state_d == ST_GRANT) ? (ONE_HOT0 << owner_d) : '0;
    end

    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_ptr_q  <= LAST_REQ;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            grant       <= '0;
            abort_pulse <= 1'b0;
            trunc_pulse <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_ptr_q  <= last_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            grant       <= grant_d;
            abort_pulse <= abort_d;
            trunc_pulse <= trunc_d;
        end
    end
endmodule

// File: tb/tb_bt_tx_arbiter.sv
// Bench for bt_tx_arbiter: reset/table vectors, directed multi-cycle sequences and a random run against a reference model.
module tb_bt_tx_arbiter;
    localparam int N    = 4;
    localparam int MAXL = 4;
    localparam int TO   = 8;

    logic          clk_rx = 1'b0;
    logic          rst_clk_rx;
    logic [N-1:0]  req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic [7:0]    tx_data;
    logic          tx_buf_en, tx_buf_full, busy, abort_pulse, trunc_pulse;

    bt_tx_arbiter #(.NUM_REQ(N), .MAX_PKT_LEN(MAXL), .IDLE_TIMEOUT(TO)) dut (
        .clk_rx      (clk_rx),
        .rst_clk_rx  (rst_clk_rx),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_buf_en   (tx_buf_en),
        .tx_buf_full (tx_buf_full),
        .grant       (grant),
        .busy        (busy),
        .abort_pulse (abort_pulse),
        .trunc_pulse (trunc_pulse)
    );

    always #5 clk_rx = ~clk_rx;

    int checks = 0;
    int failures = 0;

    logic [N-1:0] s_grant, s_ready, acc, prev_grant;
    logic         s_en, s_busy, s_abort, s_trunc;
    logic [7:0]   s_data;
    int           gnt_q[$];
    int           wr_q[$];
    int           n_abort, n_trunc;

    // Reference model state: who owns the port and the counters the rules refer to.
    bit m_known = 0;
    bit m_busy, m_abort, m_trunc;
    int m_owner, m_last_ptr, m_bytes, m_idle;

    typedef struct {
        logic [N-1:0]   valid;
        logic [8*N-1:0] data;
        logic [N-1:0]   last;
        logic           full;
        logic [N-1:0]   e_grant;
        logic [N-1:0]   e_ready;
        logic           e_en;
        logic [7:0]     e_data;
        logic           e_busy;
    } vec_t;
    vec_t tab[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg, er;
        logic         ee;
        logic [7:0]   ed;
        eg = m_busy ? N'(1 << m_owner) : '0;
        er = (m_busy && !tx_buf_full) ? eg : '0;
        ee = m_busy && req_valid[m_owner] && !tx_buf_full;
        ed = m_busy ? req_data[8*m_owner +: 8] : 8'h00;
        chk("model_grant", 32'(s_grant), 32'(eg));
        chk("model_ready", 32'(s_ready), 32'(er));
        chk("model_tx_buf_en", 32'(s_en), 32'(ee));
        chk("model_tx_data", 32'(s_data), 32'(ed));
        chk("model_busy", 32'(s_busy), 32'(m_busy));
        chk("model_abort", 32'(s_abort), 32'(m_abort));
        chk("model_trunc", 32'(s_trunc), 32'(m_trunc));
    endtask

    task automatic model_advance();
        int c;
        if (rst_clk_rx) begin
            m_known = 1; m_busy = 0; m_owner = 0; m_last_ptr = N - 1;
            m_bytes = 0; m_idle = 0; m_abort = 0; m_trunc = 0;
            return;
        end
        m_abort = 0;
        m_trunc = 0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last_ptr + k) % N;
                if (req_valid[c]) begin
                    m_busy = 1; m_owner = c; m_bytes = 0; m_idle = 0;
                    break;
                end
            end
        end else if (req_valid[m_owner] && !tx_buf_full) begin
            m_bytes = (m_bytes < 255) ? m_bytes + 1 : 255;
            m_idle  = 0;
            if (req_last[m_owner]) begin
                m_busy = 0; m_last_ptr = m_owner;
            end else if (m_bytes == MAXL) begin
                m_busy = 0; m_last_ptr = m_owner; m_trunc = 1;
            end
        end else if (!req_valid[m_owner]) begin
            m_idle = (m_idle < 65535) ? m_idle + 1 : 65535;
            if (m_idle == TO) begin
                m_busy = 0; m_last_ptr = m_owner; m_abort = 1;
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs are sampled and checked at the following negedge.
    task automatic cycle();
        @(negedge clk_rx);
        s_grant = grant; s_ready = req_ready; s_en = tx_buf_en; s_data = tx_data;
        s_busy = busy; s_abort = abort_pulse; s_trunc = trunc_pulse;
        acc = req_ready & req_valid;
        if (m_known) model_check();
        if (tx_buf_en) wr_q.push_back(int'(tx_data));
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < N; i++) if (grant[i]) gnt_q.push_back(i);
        prev_grant = grant;
        if (abort_pulse) n_abort++;
        if (trunc_pulse) n_trunc++;
        model_advance();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic rst_seq();
        req_valid = '0; req_last = '0; req_data = '0; tx_buf_full = 1'b0;
        rst_clk_rx = 1'b1;
        cycle();
        cycle();
        rst_clk_rx = 1'b0;
        wr_q.delete(); gnt_q.delete(); n_abort = 0; n_trunc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, fulls, lows, ci[3];
        bit seen, done2;

        tab[0] = '{4'b0001, 32'h41, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        tab[1] = '{4'b0001, 32'h41, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h41, 1'b1};
        tab[2] = '{4'b0001, 32'h42, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h42, 1'b1};
        tab[3] = '{4'b0001, 32'h43, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h43, 1'b1};
        tab[4] = '{4'b0000, 32'h00, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        tab[5] = '{4'b0000, 32'h00, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};

        prev_grant = '0;
        rst_seq();

        // Row 0 doubles as the reset-state check.
        for (int r = 0; r < 6; r++) begin
            req_valid = tab[r].valid; req_data = tab[r].data;
            req_last = tab[r].last; tx_buf_full = tab[r].full;
            cycle();
            chk("tab_grant", 32'(s_grant), 32'(tab[r].e_grant));
            chk("tab_ready", 32'(s_ready), 32'(tab[r].e_ready));
            chk("tab_tx_buf_en", 32'(s_en), 32'(tab[r].e_en));
            chk("tab_tx_data", 32'(s_data), 32'(tab[r].e_data));
            chk("tab_busy", 32'(s_busy), 32'(tab[r].e_busy));
            chk("tab_pulses", 32'({s_abort, s_trunc}), 32'h0);
        end

        // Three requesters with continuous 2-byte packets.
        rst_seq();
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            ci[i] = 0;
            req_data[8*i +: 8] = 8'(i << 4);
        end
        for (int t = 0; t < 80 && wr_q.size() < 12; t++) begin
            cycle();
            for (int i = 0; i < 3; i++)
                if (acc[i]) begin
                    ci[i]++;
                    req_data[8*i +: 8] = 8'((i << 4) | ci[i]);
                    req_last[i] = ci[i][0];
                end
        end
        req_valid = '0;
        cycle();
        for (int p = 0; p < 6; p++) begin
            chk("rr_grant_order", (p < gnt_q.size()) ? gnt_q[p] : -1, p % 3);
            for (int b = 0; b < 2; b++)
                chk("rr_byte", (2*p + b < wr_q.size()) ? wr_q[2*p + b] : -1,
                    ((p % 3) << 4) | (2 * (p / 3) + b));
        end

        // Ten cycles of FIFO full in the middle of a 4-byte packet.
        rst_seq();
        k = 0; fulls = 0;
        req_valid = 4'b0001; req_data[7:0] = 8'h10;
        for (int t = 0; t < 40 && k < 4; t++) begin
            tx_buf_full = (k == 2 && fulls < 10);
            cycle();
            if (tx_buf_full) begin
                fulls++;
                chk("bp_tx_buf_en", 32'(s_en), 32'h0);
                chk("bp_ready", 32'(s_ready), 32'h0);
            end
            if (acc[0]) begin
                k++;
                req_data[7:0] = 8'(8'h10 + k);
                req_last[0] = (k == 3);
            end
        end
        tx_buf_full = 1'b0; req_valid = '0;
        cycle();
        chk("bp_full_cycles", fulls, 10);
        chk("bp_abort_count", n_abort, 0);
        chk("bp_byte_count", wr_q.size(), 4);
        for (int b = 0; b < 4; b++)
            chk("bp_byte", (b < wr_q.size()) ? wr_q[b] : -1, 16 + b);

        // Owner goes silent after one byte; req1 waits.
        rst_seq();
        req_valid = 4'b0011; req_data[7:0] = 8'h50; req_data[15:8] = 8'h60; req_last = 4'b0010;
        cycle();
        cycle();
        chk("to_first_byte_en", 32'(s_en), 32'h1);
        req_valid[0] = 1'b0;
        lows = 0; seen = 0;
        for (int t = 0; t < 30 && !seen; t++) begin
            cycle();
            if (s_abort) seen = 1;
            else lows++;
        end
        chk("to_abort_seen", 32'(seen), 32'h1);
        chk("to_idle_cycles", lows, TO);
        cycle();
        chk("to_next_grant", 32'(s_grant), 32'h2);
        chk("to_next_data", 32'(s_data), 32'h60);
        req_valid = '0;
        cycle();

        // req1 streams 6 bytes without last while req2 waits with a 1-byte packet.
        rst_seq();
        k = 0; done2 = 0;
        req_valid = 4'b0110; req_data[15:8] = 8'h30; req_data[23:16] = 8'h77; req_last = 4'b0100;
        for (int t = 0; t < 60 && (k < 6 || !done2); t++) begin
            cycle();
            if (acc[1]) begin
                k++;
                if (k == 6) req_valid[1] = 1'b0;
                else req_data[15:8] = 8'(8'h30 + k);
            end
            if (acc[2]) begin
                done2 = 1;
                req_valid[2] = 1'b0;
            end
        end
        req_valid = '0;
        chk("tr_trunc_count", n_trunc, 1);
        chk("tr_first_owner", (gnt_q.size() > 0) ? gnt_q[0] : -1, 1);
        chk("tr_second_owner", (gnt_q.size() > 1) ? gnt_q[1] : -1, 2);
        for (int b = 0; b < 7; b++)
            chk("tr_byte", (b < wr_q.size()) ? wr_q[b] : -1, (b < 4) ? 8'h30 + b : (b == 4) ? 8'h77 : 8'h30 + b - 1);

        // Reset while the second byte of a packet is on the bus.
        rst_seq();
        req_valid = 4'b0001; req_data[7:0] = 8'h20;
        cycle();
        cycle();
        req_data[7:0] = 8'h21;
        rst_clk_rx = 1'b1;
        cycle();
        rst_clk_rx = 1'b0;
        req_valid = 4'b0011; req_data[7:0] = 8'h20; req_data[15:8] = 8'h99; req_last = '0;
        cycle();
        chk("rst_grant_dropped", 32'(s_grant), 32'h0);
        chk("rst_tx_buf_en", 32'(s_en), 32'h0);
        cycle();
        chk("rst_tie_winner", 32'(s_grant), 32'h1);
        req_valid = '0;

        // Random protocol-compliant traffic checked cycle by cycle against the model.
        rst_seq();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tx_buf_full = ($urandom_range(0, 3) == 0);
            cycle();
            for (int i = 0; i < N; i++)
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_data[8*i +: 8] = 8'($urandom);
                    req_last[i] = ($urandom_range(0, 3) == 0);
                end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
